// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter generator.
// Next-PC source codes, FSM states and parameter legality checks.
package pc_pkg;

    // Next-PC source selector codes; 5-7 are decoded as sequential.
    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JALR   = 3'd2,
        PC_TRAP   = 3'd3,
        PC_MRET   = 3'd4
    } pc_sel_e;

    // Run/halt control states.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_e;

    localparam int SEL_W = 3;

    // Instruction alignment is either compressed (2) or base (4) only.
    function automatic bit ialign_legal(input int ialign);
        return (ialign == 2) || (ialign == 4);
    endfunction

    // Illegal alignments fall back to the base-ISA value of 4.
    function automatic int ialign_eff(input int ialign);
        return ialign_legal(ialign) ? ialign : 4;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC target selection and alignment check.
// Pure logic; all state lives in pc_gen.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
    parameter int              IALIGN   = 4
) (
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [XLEN-1:0]  immext,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  epc,
    input  logic [SEL_W-1:0] pc_sel,
    output logic [XLEN-1:0]  tgt,
    output logic             is_trap,
    output logic             tgt_bad
);

    localparam int IA = ialign_eff(IALIGN);

    logic            is_br;
    logic            is_jalr;
    logic            is_mret;
    logic            chk_align;
    logic            low_bad;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;

    assign is_br   = (pc_sel == PC_BRANCH);
    assign is_jalr = (pc_sel == PC_JALR);
    assign is_trap = (pc_sel == PC_TRAP);
    assign is_mret = (pc_sel == PC_MRET);

    assign br_tgt   = pc + immext;
    assign jalr_sum = rs1 + immext;
    assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

    // One-hot source decode; anything unrecognised is sequential.
    always_comb begin
        tgt       = pc_plus4;
        chk_align = 1'b0;
        unique case (1'b1)
            is_br: begin
                tgt       = br_tgt;
                chk_align = 1'b1;
            end
            is_jalr: begin
                tgt       = jalr_tgt;
                chk_align = 1'b1;
            end
            is_trap: begin
                tgt = TRAP_VEC;
            end
            is_mret: begin
                tgt       = epc;
                chk_align = 1'b1;
            end
            default: begin
                tgt = pc_plus4;
            end
        endcase
    end

    // Alignment granularity follows IALIGN.
    if (IA == 4) begin : g_ia4
        assign low_bad = |tgt[1:0];
    end else begin : g_ia2
        assign low_bad = tgt[0];
    end

    assign tgt_bad = chk_align & low_bad;

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: PC/EPC registers, halt FSM,
// misaligned-target trapping and retired-instruction counter.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              IALIGN    = 4,
    parameter int              CNT_W     = 64
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             stall,
    input  logic [2:0]       pc_sel,
    input  logic [XLEN-1:0]  immext,
    input  logic [XLEN-1:0]  rs1,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  epc,
    output logic             misaligned,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    pc_state_e       state;
    logic            update;
    logic [XLEN-1:0] tgt;
    logic            is_trap;
    logic            tgt_bad;
    logic            redirect;

    assign update   = (state == ST_RUN) && !stall;
    assign pc_plus4 = pc + XLEN'(4);
    assign halted   = (state == ST_HALTED);
    assign redirect = is_trap || tgt_bad;

    pc_next_mux #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .IALIGN   (IALIGN)
    ) u_mux (
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .immext   (immext),
        .rs1      (rs1),
        .epc      (epc),
        .pc_sel   (pc_sel),
        .tgt      (tgt),
        .is_trap  (is_trap),
        .tgt_bad  (tgt_bad)
    );

    // Run/halt FSM; the halting edge still retires one instruction.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req && !stall) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // PC and exception PC; traps and bad targets vector to TRAP_VEC.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pc  <= RESET_VEC;
            epc <= '0;
        end else if (update) begin
            if (redirect) begin
                pc  <= TRAP_VEC;
                epc <= pc;
            end else begin
                pc  <= tgt;
            end
        end
    end

    // One-cycle pulse marking a redirect caused by a misaligned target.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= update && tgt_bad;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            instret <= '0;
        end else if (update) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Randomised self-checking bench for pc_gen.
// Two instances (IALIGN=4/CNT_W=64, IALIGN=2/CNT_W=4) share stimulus.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic [31:0] immext = '0;
    logic [31:0] rs1 = '0;

    logic [31:0] pc_a, pc4_a, epc_a;
    logic [31:0] pc_b, pc4_b, epc_b;
    logic        mis_a, hlt_a, mis_b, hlt_b;
    logic [63:0] ret_a;
    logic [3:0]  ret_b;

    int checks = 0;
    int failures = 0;

    logic [31:0] pc_m [2];
    logic [31:0] epc_m [2];
    bit          mis_m [2];
    logic [63:0] ret_m [2];
    bit          halt_m;

    always #5 clk = ~clk;

    pc_gen dut_a (
        .clk(clk), .arst(arst), .stall(stall), .pc_sel(pc_sel),
        .immext(immext), .rs1(rs1), .halt_req(halt_req),
        .resume(resume), .pc(pc_a), .pc_plus4(pc4_a), .epc(epc_a),
        .misaligned(mis_a), .halted(hlt_a), .instret(ret_a)
    );

    pc_gen #(.IALIGN(2), .CNT_W(4)) dut_b (
        .clk(clk), .arst(arst), .stall(stall), .pc_sel(pc_sel),
        .immext(immext), .rs1(rs1), .halt_req(halt_req),
        .resume(resume), .pc(pc_b), .pc_plus4(pc4_b), .epc(epc_b),
        .misaligned(mis_b), .halted(hlt_b), .instret(ret_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pc_m[k]  = 32'h0;
            epc_m[k] = 32'h0;
            mis_m[k] = 1'b0;
            ret_m[k] = 64'h0;
        end
        halt_m = 1'b0;
    endtask

    // Reference: what one clock edge does to the architectural state.
    task automatic model_edge();
        logic [31:0] t;
        logic [31:0] s;
        bit          bad;
        bit          run;
        int          ia;
        run = !halt_m && !stall;
        for (int k = 0; k < 2; k++) begin
            ia = (k == 0) ? 4 : 2;
            mis_m[k] = 1'b0;
            if (run) begin
                bad = 1'b0;
                case (pc_sel)
                    3'd1: t = pc_m[k] + immext;
                    3'd2: begin
                        s = rs1 + immext;
                        t = s - (s % 2);
                    end
                    3'd3: t = 32'h100;
                    3'd4: t = epc_m[k];
                    default: t = pc_m[k] + 32'd4;
                endcase
                if (pc_sel inside {3'd1, 3'd2, 3'd4})
                    bad = (t % ia) != 0;
                if (pc_sel == 3'd3 || bad) begin
                    epc_m[k] = pc_m[k];
                    pc_m[k]  = 32'h100;
                    mis_m[k] = bad;
                end else begin
                    pc_m[k] = t;
                end
                ret_m[k] = ret_m[k] + 64'd1;
            end
        end
        if (!halt_m) begin
            if (halt_req && !stall) halt_m = 1'b1;
        end else if (resume) begin
            halt_m = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".pc_a"}, 64'(pc_a), 64'(pc_m[0]));
        chk({tag, ".pc4_a"}, 64'(pc4_a), 64'(pc_m[0] + 32'd4));
        chk({tag, ".epc_a"}, 64'(epc_a), 64'(epc_m[0]));
        chk({tag, ".mis_a"}, 64'(mis_a), 64'(mis_m[0]));
        chk({tag, ".hlt_a"}, 64'(hlt_a), 64'(halt_m));
        chk({tag, ".ret_a"}, ret_a, ret_m[0]);
        chk({tag, ".pc_b"}, 64'(pc_b), 64'(pc_m[1]));
        chk({tag, ".epc_b"}, 64'(epc_b), 64'(epc_m[1]));
        chk({tag, ".mis_b"}, 64'(mis_b), 64'(mis_m[1]));
        chk({tag, ".hlt_b"}, 64'(hlt_b), 64'(halt_m));
        chk({tag, ".ret_b"}, 64'(ret_b), ret_m[1] % 64'd16);
    endtask

    task automatic step(input string tag, input logic [2:0] s,
                        input logic [31:0] im, input logic [31:0] r,
                        input bit st, input bit hr, input bit rs);
        pc_sel   = s;
        immext   = im;
        rs1      = r;
        stall    = st;
        halt_req = hr;
        resume   = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        arst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        int upd;
        model_reset();
        #12;
        arst = 1'b0;
        #1;
        compare_all("por");

        // Run a little, then reset between edges.
        for (int i = 0; i < 4; i++) step("pre", 3'd0, 0, 0, 0, 0, 0);
        step("pre_halt", 3'd0, 0, 0, 0, 1, 0);
        async_reset("midrst");
        chk("midrst.pc", 64'(pc_a), 64'h0);
        chk("midrst.halted", 64'(hlt_a), 64'h0);

        // Sequential and branch.
        step("br10", 3'd1, 32'h10, 0, 0, 0, 0);
        step("seq", 3'd0, 0, 0, 0, 0, 0);
        chk("seq.const", 64'(pc_a), 64'h14);
        step("brm8", 3'd1, 32'hFFFF_FFF8, 0, 0, 0, 0);
        chk("brm8.const", 64'(pc_a), 64'h0C);
        chk("brm8.ret", ret_a, 64'd3);

        // JALR aligned and misaligned.
        step("jalr_ok", 3'd2, 32'h4, 32'h1001, 0, 0, 0);
        chk("jalr_ok.const", 64'(pc_a), 64'h1004);
        step("jalr_bad", 3'd2, 32'h4, 32'h1003, 0, 0, 0);
        chk("jalr_bad.pc", 64'(pc_a), 64'h100);
        chk("jalr_bad.epc", 64'(epc_a), 64'h1004);
        chk("jalr_bad.mis", 64'(mis_a), 64'h1);
        chk("jalr_bad.pc_b", 64'(pc_b), 64'h1006);
        step("mis_clr", 3'd0, 0, 0, 0, 0, 0);
        chk("mis_clr.const", 64'(mis_a), 64'h0);

        // Trap held off by stall, then taken, then returned from.
        step("to40", 3'd2, 32'h0, 32'h40, 0, 0, 0);
        step("trap_st1", 3'd3, 0, 0, 1, 0, 0);
        step("trap_st2", 3'd3, 0, 0, 1, 0, 0);
        chk("trap_st.const", 64'(pc_a), 64'h40);
        step("trap", 3'd3, 0, 0, 0, 0, 0);
        chk("trap.pc", 64'(pc_a), 64'h100);
        chk("trap.epc", 64'(epc_a), 64'h40);
        step("mret", 3'd4, 0, 0, 0, 0, 0);
        chk("mret.const", 64'(pc_a), 64'h40);

        // Halt, hold, resume.
        step("to20", 3'd2, 32'h0, 32'h20, 0, 0, 0);
        step("halt", 3'd0, 0, 0, 0, 1, 0);
        chk("halt.pc", 64'(pc_a), 64'h24);
        chk("halt.flag", 64'(hlt_a), 64'h1);
        for (int i = 0; i < 3; i++)
            step("hold", 3'($urandom_range(0, 7)), $urandom, $urandom,
                 1'($urandom), 1'($urandom), 0);
        chk("hold.pc", 64'(pc_a), 64'h24);
        step("resume", 3'd1, 32'h80, 0, 1, 1, 1);
        chk("resume.flag", 64'(hlt_a), 64'h0);
        chk("resume.pc", 64'(pc_a), 64'h24);
        step("post", 3'd0, 0, 0, 0, 0, 0);
        chk("post.const", 64'(pc_a), 64'h28);

        // Counter wrap on the 4-bit instance with stalls mixed in.
        async_reset("wraprst");
        upd = 0;
        while (upd < 17) begin
            bit st;
            st = ($urandom_range(0, 3) == 0);
            step("wrap", 3'd0, 0, 0, st, 0, 0);
            if (!st) upd++;
        end
        chk("wrap.ret_b", 64'(ret_b), 64'd1);
        chk("wrap.ret_a", ret_a, 64'd17);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] im;
            im = 32'($urandom_range(0, 63)) - 32'd32;
            step("rnd", 3'($urandom_range(0, 7)), im,
                 32'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
